pe_dot_scheduler: RTL and testbench

- Round-robin scheduler that shares one dot-product PE (16-bit f × 32-bit g, 64-bit signed accumulator) among NREQ requesters in the ICA update pipeline.
- For each granted job it clears the PE, waits a fixed warm-up for operand memories to settle, and streams VLEN element indices to the granted requester's operand memories.
- It gates PE accumulation to line up with operand read latency, then captures the final 64-bit accumulator and returns it with a done pulse.

---
 rtl/pe_dot_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_pe_dot_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dot_scheduler.sv
// ---------------------------------------------------------------------------
// pe_dot_scheduler
//
// Shares one dot-product PE (16-bit f x 32-bit g into a 64-bit signed
// accumulator) among NREQ requesters of the ICA update pipeline. The
// arbiter is round-robin. Each granted job goes through these steps:
//   1. Clear the PE accumulator.
//   2. Wait WARMUP cycles so the requester's operand memories settle.
//   3. Stream element indices 0..VLEN-1 to the operand memories.
//   4. Enable PE accumulation RDLAT cycles behind each index, which lines
//      it up with the memory read latency.
//   5. Capture the final accumulator into result and pulse done.
//
// Ports
//   clk      in   rising-edge clock for all logic
//   rst      in   synchronous active-high reset; aborts any job in flight
//   req      in   [NREQ]  per-requester job request level (sampled in IDLE)
//   gnt      out  [NREQ]  one-hot grant, held for the whole job
//   done     out  [NREQ]  one-cycle pulse on the granted bit, result valid
//   busy     out          high whenever a job is in progress
//   idx      out  [IDXW]  element index to the operand memories
//   idx_vld  out          idx is valid this cycle
//   pe_clr   out          one-cycle accumulator clear to the PE
//   pe_en    out          PE accumulate enable (idx_vld delayed RDLAT cycles)
//   pe_acc   in   [64]    signed PE accumulator value
//   result   out  [64]    signed captured dot product, held until next capture
//
// Timing with req sampled in cycle 0:
//   gnt is high in cycles 1..L and done pulses in cycle L, where
//   L = 1 + WARMUP + VLEN + RDLAT + 1.
//   When req is still pending, back-to-back jobs are separated by one
//   IDLE cycle.
// ---------------------------------------------------------------------------
module pe_dot_scheduler #(
    parameter int NREQ   = 4,
    parameter int VLEN   = 64,
    parameter int IDXW   = 6,
    parameter int WARMUP = 36,
    parameter int RDLAT  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [IDXW-1:0]         idx,
    output logic                    idx_vld,
    output logic                    pe_clr,
    output logic                    pe_en,
    input  logic signed [63:0]      pe_acc,
    output logic signed [63:0]      result
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // One shared counter times both the warm-up and the drain phases.
    // The stream phase is timed by idx itself.
    localparam int CNT_MAX = (WARMUP > RDLAT + 1) ? WARMUP : RDLAT + 1;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] WARM_LAST  = CNTW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(RDLAT);
    localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(VLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARM,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNTW-1:0]   cnt;
    logic [PTRW-1:0]   last;      // most recently served requester
    logic [PTRW-1:0]   win_q;     // requester owning the current job
    logic [PTRW-1:0]   winner;    // arbitration result (valid when found)
    logic [PTRW-1:0]   cand;
    logic              found;

    // -----------------------------------------------------------------------
    // Round-robin arbiter. The search starts one past the last served
    // requester and wraps, so a requester that holds req high is served
    // within NREQ jobs.
    // -----------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default on entry.
    // Without that, a path that skips the assignment infers a latch.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTRW'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state;
        busy    = 1'b1;
        idx_vld = 1'b0;
        done    = '0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (found) begin
                    // With no warm-up, the job goes straight to streaming.
                    state_n = (WARMUP == 0) ? S_STREAM : S_WARM;
                end
            end
            S_WARM: begin
                if (cnt == WARM_LAST) begin
                    state_n = S_STREAM;
                end
            end
            S_STREAM: begin
                idx_vld = 1'b1;
                if (idx == IDX_LAST) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // RDLAT+1 cycles: the last delayed pe_en, then the PE
                // register update that it causes.
                if (cnt == DRAIN_LAST) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done    = gnt;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the values from before the edge, whatever
    // order the statements are written in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            gnt    <= '0;
            pe_clr <= 1'b0;
            win_q  <= '0;
            last   <= PTRW'(NREQ - 1);   // req[0] has top priority after reset
            result <= '0;
        end else begin
            state <= state_n;

            // The counter restarts on every state change. It only advances
            // in the phases it times.
            if (state_n != state) begin
                cnt <= '0;
            end else if (state == S_WARM || state == S_DRAIN) begin
                cnt <= cnt + CNTW'(1);
            end

            // The clear pulse lands in the first cycle of the job, whether
            // that cycle is in WARM or in STREAM.
            pe_clr <= (state == S_IDLE) && found;

            if (state == S_IDLE && found) begin
                gnt   <= NREQ'(1) << winner;
                win_q <= winner;
            end else if (state == S_DONE) begin
                gnt <= '0;
            end

            if (state == S_STREAM) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
            end

            if (state == S_DRAIN && cnt == DRAIN_LAST) begin
                result <= pe_acc;
            end

            if (state == S_DONE) begin
                last <= win_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // pe_en: idx_vld delayed by the operand read latency
    // -----------------------------------------------------------------------
    generate
        if (RDLAT == 0) begin : g_en_direct
            assign pe_en = idx_vld;
        end else begin : g_en_delay
            logic [RDLAT-1:0] vld_sr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_sr <= '0;
                end else begin
                    vld_sr <= (vld_sr << 1) | RDLAT'(idx_vld);
                end
            end

            assign pe_en = vld_sr[RDLAT-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Structural invariants
    // -----------------------------------------------------------------------
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_done_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(done));
    a_done_in_gnt : assert property (@(posedge clk) disable iff (rst) (done & ~gnt) == '0);

endmodule

// File: tb/tb_pe_dot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pe_dot_scheduler
//
// Drives two instances of the scheduler:
//   u_dut_a  default parameters; all job-level behaviour is checked here.
//   u_dut_b  WARMUP=0, RDLAT=0, VLEN=4; covers the parameter corner.
//
// The bench also holds a behavioural operand memory and PE for each
// instance. The reference model works at job level:
//   - the round-robin choice is a plain search over the request bits;
//   - the expected result is the arithmetic sum of f[i]*g[i];
//   - the expected waveform is a set of cycle windows derived from
//     the latency formula.
// ---------------------------------------------------------------------------
module tb_pe_dot_scheduler;

    localparam int NREQ   = 4;
    localparam int VLEN   = 64;
    localparam int IDXW   = 6;
    localparam int WARMUP = 36;
    localparam int RDLAT  = 1;
    localparam int L      = 1 + WARMUP + VLEN + RDLAT + 1;   // 103

    localparam int VLEN_B = 4;
    localparam int L_B    = 1 + 0 + VLEN_B + 0 + 1;          // 6

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [NREQ-1:0]    req_a, gnt_a, done_a;
    logic               busy_a, idx_vld_a, pe_clr_a, pe_en_a;
    logic [IDXW-1:0]    idx_a;
    logic signed [63:0] acc_a, result_a;

    logic [NREQ-1:0]    req_b, gnt_b, done_b;
    logic               busy_b, idx_vld_b, pe_clr_b, pe_en_b;
    logic [1:0]         idx_b;
    logic signed [63:0] acc_b, result_b;

    pe_dot_scheduler #(
        .NREQ(NREQ), .VLEN(VLEN), .IDXW(IDXW), .WARMUP(WARMUP), .RDLAT(RDLAT)
    ) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .done(done_a),
        .busy(busy_a), .idx(idx_a), .idx_vld(idx_vld_a), .pe_clr(pe_clr_a),
        .pe_en(pe_en_a), .pe_acc(acc_a), .result(result_a)
    );

    pe_dot_scheduler #(
        .NREQ(NREQ), .VLEN(VLEN_B), .IDXW(2), .WARMUP(0), .RDLAT(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .done(done_b),
        .busy(busy_b), .idx(idx_b), .idx_vld(idx_vld_b), .pe_clr(pe_clr_b),
        .pe_en(pe_en_b), .pe_acc(acc_b), .result(result_b)
    );

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Operand memories and PE models
    // -----------------------------------------------------------------------
    logic signed [15:0] f_mem [NREQ][VLEN];
    logic signed [31:0] g_mem [NREQ][VLEN];
    logic signed [15:0] fb_mem [VLEN_B];
    logic signed [31:0] gb_mem [VLEN_B];

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Instance A: memory with a one-cycle registered read, addressed by the
    // granted requester.
    logic signed [15:0] fa_q;
    logic signed [31:0] ga_q;
    int                 sel_a;
    assign sel_a = oh_idx(gnt_a);

    // A clear that coincides with an enable starts a fresh sum with that
    // product.
    initial acc_a = '0;
    always @(posedge clk) begin
        fa_q <= f_mem[sel_a][idx_a];
        ga_q <= g_mem[sel_a][idx_a];
        if (pe_clr_a) acc_a <= pe_en_a ? longint'(fa_q) * longint'(ga_q) : 64'sd0;
        else if (pe_en_a) acc_a <= acc_a + longint'(fa_q) * longint'(ga_q);
    end

    // Instance B: memory with a combinational read.
    initial acc_b = '0;
    always @(posedge clk) begin
        if (pe_clr_b) acc_b <= pe_en_b ? longint'(fb_mem[idx_b]) * longint'(gb_mem[idx_b]) : 64'sd0;
        else if (pe_en_b) acc_b <= acc_b + longint'(fb_mem[idx_b]) * longint'(gb_mem[idx_b]);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int model_last = NREQ - 1;

    function automatic int model_pick(input logic [NREQ-1:0] r, input int lst);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic longint model_dot(input int w);
        longint s = 0;
        for (int i = 0; i < VLEN; i++) s += longint'(f_mem[w][i]) * longint'(g_mem[w][i]);
        return s;
    endfunction

    task automatic fill_rand();
        for (int r = 0; r < NREQ; r++)
            for (int i = 0; i < VLEN; i++) begin
                f_mem[r][i] = 16'($urandom);
                g_mem[r][i] = 32'($urandom);
            end
    endtask

    task automatic fill_const(input logic signed [15:0] fv, input logic signed [31:0] gv);
        for (int r = 0; r < NREQ; r++)
            for (int i = 0; i < VLEN; i++) begin
                f_mem[r][i] = fv;
                g_mem[r][i] = gv;
            end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = NREQ - 1;
    endtask

    // One job on instance A. It is entered at the negedge of an IDLE cycle
    // (cycle 0) and returns at the negedge of the IDLE cycle that follows
    // done. That cycle can serve as cycle 0 of the next job.
    // Windows (1-based cycles):
    //   gnt      1..L
    //   pe_clr   1
    //   idx_vld  WARMUP+1 .. WARMUP+VLEN
    //   pe_en    idx_vld window shifted by RDLAT
    //   done     L
    task automatic run_job(input logic [NREQ-1:0] r_start, input logic [NREQ-1:0] r_after,
                           input string tag, output logic [NREQ-1:0] first_gnt,
                           output int rise_cyc);
        int              w;
        logic [NREQ-1:0] exp_g;
        longint          exp_res;
        int bad_gnt, bad_vld, bad_idx, bad_en, bad_clr, bad_busy, n_done, done_at;
        logic [NREQ-1:0] done_val;
        logic            exp_vld, exp_en;

        bad_gnt = 0; bad_vld = 0; bad_idx = 0; bad_en = 0; bad_clr = 0;
        bad_busy = 0; n_done = 0; done_at = -1; done_val = '0;

        check($sformatf("%s idle_before", tag), busy_a, 1'b0);
        w       = model_pick(r_start, model_last);
        exp_g   = NREQ'(1) << w;
        exp_res = model_dot(w);
        req_a   = r_start;
        first_gnt = '0;
        rise_cyc  = 0;

        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            if (c == 1) begin
                first_gnt = gnt_a;
                rise_cyc  = cyc;
                req_a     = r_after;   // changes after the grant must not matter
            end
            exp_vld = (c >= WARMUP + 1) && (c <= WARMUP + VLEN);
            exp_en  = (c >= WARMUP + 1 + RDLAT) && (c <= WARMUP + VLEN + RDLAT);
            if (gnt_a !== exp_g) bad_gnt++;
            if (busy_a !== 1'b1) bad_busy++;
            if (idx_vld_a !== exp_vld) bad_vld++;
            if (exp_vld && idx_a !== IDXW'(c - 1 - WARMUP)) bad_idx++;
            if (!exp_vld && idx_a !== '0) bad_idx++;
            if (pe_en_a !== exp_en) bad_en++;
            if (pe_clr_a !== (c == 1)) bad_clr++;
            if (done_a !== '0) begin
                n_done++;
                if (done_at < 0) begin
                    done_at  = c;
                    done_val = done_a;
                end
            end
        end

        check($sformatf("%s gnt_window_errors", tag), bad_gnt, 0);
        check($sformatf("%s busy_window_errors", tag), bad_busy, 0);
        check($sformatf("%s idx_vld_window_errors", tag), bad_vld, 0);
        check($sformatf("%s idx_sequence_errors", tag), bad_idx, 0);
        check($sformatf("%s pe_en_window_errors", tag), bad_en, 0);
        check($sformatf("%s pe_clr_errors", tag), bad_clr, 0);
        check($sformatf("%s done_cycle", tag), done_at, L);
        check($sformatf("%s done_pulses", tag), n_done, 1);
        check($sformatf("%s done_value", tag), done_val, exp_g);
        check($sformatf("%s result", tag), result_a, exp_res);

        @(negedge clk);
        check($sformatf("%s gnt_after", tag), gnt_a, '0);
        check($sformatf("%s busy_after", tag), busy_a, 1'b0);
        check($sformatf("%s result_held", tag), result_a, exp_res);
        if (w >= 0) model_last = w;
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [NREQ-1:0] fg;
        int              rise, prev_rise;
        int bad_b;
        int done_b_at;
        longint exp_b;

        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        fill_rand();
        repeat (3) @(negedge clk);

        // Reset state on both instances.
        check("rst gnt_a", gnt_a, '0);
        check("rst done_a", done_a, '0);
        check("rst busy_a", busy_a, 1'b0);
        check("rst idx_a", idx_a, '0);
        check("rst idx_vld_a", idx_vld_a, 1'b0);
        check("rst pe_clr_a", pe_clr_a, 1'b0);
        check("rst pe_en_a", pe_en_a, 1'b0);
        check("rst result_a", result_a, '0);
        check("rst gnt_b", gnt_b, '0);
        check("rst result_b", result_b, '0);
        rst = 1'b0;
        model_last = NREQ - 1;

        // Parameter corner: WARMUP=0, RDLAT=0, VLEN=4, requester 2.
        for (int i = 0; i < VLEN_B; i++) begin
            fb_mem[i] = 16'($urandom);
            gb_mem[i] = 32'($urandom);
        end
        exp_b = 0;
        for (int i = 0; i < VLEN_B; i++) exp_b += longint'(fb_mem[i]) * longint'(gb_mem[i]);
        req_b     = 4'b0100;
        bad_b     = 0;
        done_b_at = -1;
        for (int c = 1; c <= L_B + 2; c++) begin
            @(negedge clk);
            if (c == 1) req_b = '0;
            if (pe_clr_b !== (c == 1)) bad_b++;
            if (idx_vld_b !== (c <= VLEN_B)) bad_b++;
            if (pe_en_b !== idx_vld_b) bad_b++;
            if (idx_vld_b && idx_b !== 2'(c - 1)) bad_b++;
            if (gnt_b !== ((c <= L_B) ? 4'b0100 : 4'b0000)) bad_b++;
            if (done_b !== '0) begin
                if (done_b_at < 0) done_b_at = c;
                if (done_b !== 4'b0100) bad_b++;
            end
        end
        check("corner waveform_errors", bad_b, 0);
        check("corner done_cycle", done_b_at, L_B);
        check("corner result", result_b, exp_b);

        // 1. Single job with f[i]=i+1, g[i]=2.
        for (int r = 0; r < NREQ; r++)
            for (int i = 0; i < VLEN; i++) begin
                f_mem[r][i] = 16'(i + 1);
                g_mem[r][i] = 32'd2;
            end
        run_job(4'b0001, 4'b0000, "single", fg, rise);
        check("single first_gnt", fg, 4'b0001);
        check("single result_4160", result_a, 64'd4160);

        // 2. Round robin with all requests held high, back to back.
        pulse_reset();
        fill_rand();
        prev_rise = 0;
        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, 4'b1111, $sformatf("rr%0d", j), fg, rise);
            check($sformatf("rr%0d order", j), fg, 4'(1) << (j % NREQ));
            if (j > 0) check($sformatf("rr%0d spacing", j), rise - prev_rise, L + 1);
            prev_rise = rise;
        end
        req_a = '0;
        @(negedge clk);

        // 3. After serving requester 2, the search starts at 3 and wraps to 0.
        pulse_reset();
        run_job(4'b0100, 4'b0000, "prio_a", fg, rise);
        run_job(4'b0101, 4'b0000, "prio_b", fg, rise);
        check("prio wrap_to_0", fg, 4'b0001);

        // 4. Reset during cycle 60 of a job.
        req_a = 4'b0001;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) req_a = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort gnt", gnt_a, '0);
        check("abort done", done_a, '0);
        check("abort busy", busy_a, 1'b0);
        check("abort idx_vld", idx_vld_a, 1'b0);
        check("abort pe_en", pe_en_a, 1'b0);
        check("abort result", result_a, '0);
        rst   = 1'b0;
        req_a = 4'b0010;
        @(negedge clk);
        check("abort regrant", gnt_a, 4'b0010);
        req_a = '0;
        pulse_reset();
        run_job(4'b1111, 4'b0000, "abort_prio", fg, rise);
        check("abort req0_top", fg, 4'b0001);

        // 5. Largest-magnitude negative product; needs the full 64 bits.
        fill_const(-16'sd32768, 32'sd2147483647);
        run_job(4'b1000, 4'b0000, "neg", fg, rise);
        check("neg exact", result_a, 64'(longint'(-32768) * longint'(2147483647) * 64));

        // Randomized jobs: request patterns, mid-job changes and operands.
        for (int j = 0; j < 6; j++) begin
            fill_rand();
            run_job(4'($urandom_range(1, 15)), 4'($urandom), $sformatf("rand%0d", j), fg, rise);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
